// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state type and framing constants.
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_CLK_DIV = 78;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, restartable via clr.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == CW'(CLK_DIV - 1));
    assign tick   = w_wrap & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and break detection.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxdv,
    output logic       frame_err,
    output logic       idle
);

    uart_state_t r_state, w_nextState;

    logic       r_rxMeta, r_rxSync, r_rxPrev;
    logic [1:0] r_warm;
    logic [3:0] r_tickIdx;
    logic [2:0] r_bitCnt;
    logic [3:0] r_brkCnt;
    logic       r_s7, r_s8;
    logic [7:0] r_shift, r_rxbyte;
    logic       r_rxdv, r_frameErr;

    logic w_tick, w_clr, w_fall, w_decide, w_bitEnd, w_vote;
    logic w_loadByte, w_flagErr, w_shiftIn;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // The edge register only follows real line samples once the synchronizer has
    // flushed its reset value, so a line already low at reset release is not a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxPrev <= 1'b0;
            r_warm   <= 2'd0;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            if (r_warm != 2'd2) begin
                r_warm <= r_warm + 2'd1;
            end
            r_rxPrev <= (r_warm == 2'd2) ? r_rxSync : 1'b0;
        end
    end

    assign w_fall   = r_rxPrev & ~r_rxSync;
    assign w_decide = w_tick && (r_tickIdx == 4'd9);
    assign w_bitEnd = w_tick && (r_tickIdx == 4'(OVERSAMPLE - 1));
    assign w_vote   = (r_s7 & r_s8) | (r_s7 & r_rxSync) | (r_s8 & r_rxSync);
    assign idle     = (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_clr       = 1'b0;
        w_loadByte  = 1'b0;
        w_flagErr   = 1'b0;
        w_shiftIn   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && w_fall) begin
                    w_nextState = ST_START;
                    w_clr       = 1'b1;
                end
            end
            ST_START: begin
                if (w_decide && w_vote) begin
                    w_nextState = ST_IDLE;
                end else if (w_bitEnd) begin
                    w_nextState = ST_DATA;
                end
            end
            ST_DATA: begin
                w_shiftIn = w_decide;
                if (w_bitEnd && (r_bitCnt == 3'(DATA_BITS - 1))) begin
                    w_nextState = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_decide) begin
                    if (w_vote) begin
                        w_loadByte = 1'b1;
                        if (en && w_fall) begin
                            w_nextState = ST_START;
                            w_clr       = 1'b1;
                        end else begin
                            w_nextState = ST_IDLE;
                        end
                    end else begin
                        w_flagErr   = 1'b1;
                        w_nextState = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (w_tick && r_rxSync && (r_brkCnt == 4'd15)) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
        // Dropping enable wins over anything the frame was about to report.
        if (!en && (r_state != ST_IDLE)) begin
            w_nextState = ST_IDLE;
            w_clr       = 1'b0;
            w_loadByte  = 1'b0;
            w_flagErr   = 1'b0;
            w_shiftIn   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tickIdx <= 4'd0;
            r_bitCnt  <= 3'd0;
            r_brkCnt  <= 4'd0;
            r_s7      <= 1'b0;
            r_s8      <= 1'b0;
            r_shift   <= 8'h00;
        end else begin
            if (w_clr) begin
                r_tickIdx <= 4'd0;
            end else if (w_tick) begin
                r_tickIdx <= r_tickIdx + 4'd1;
            end
            if (w_tick && (r_tickIdx == 4'd7)) begin
                r_s7 <= r_rxSync;
            end
            if (w_tick && (r_tickIdx == 4'd8)) begin
                r_s8 <= r_rxSync;
            end
            if (r_state != ST_DATA) begin
                r_bitCnt <= 3'd0;
            end else if (w_bitEnd) begin
                r_bitCnt <= r_bitCnt + 3'd1;
            end
            // Break release needs an unbroken run of high ticks; any low tick restarts it.
            if (r_state != ST_BREAK) begin
                r_brkCnt <= 4'd0;
            end else if (w_tick) begin
                r_brkCnt <= r_rxSync ? r_brkCnt + 4'd1 : 4'd0;
            end
            if (w_shiftIn) begin
                r_shift <= {w_vote, r_shift[7:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxbyte   <= 8'h00;
            r_rxdv     <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            if (w_loadByte) begin
                r_rxbyte <= r_shift;
            end
            r_rxdv     <= w_loadByte;
            r_frameErr <= w_flagErr;
        end
    end

    assign rxbyte    = r_rxbyte;
    assign rxdv      = r_rxdv;
    assign frame_err = r_frameErr;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: framed bytes, glitch, framing error, reset and enable aborts.
module tb_uart_rx_8n1;

    localparam int CLK_DIV = 4;
    localparam int BIT_CYC = CLK_DIV * 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rx;
    logic [7:0] rxbyte;
    logic       rxdv;
    logic       frame_err;
    logic       idle;

    int         checks    = 0;
    int         errors    = 0;
    int         dvCount   = 0;
    int         ferrCount = 0;
    int         bothCount = 0;
    int         dv0;
    int         fe0;
    logic [7:0] byteQ[$];

    always #5 clk = ~clk;

    uart_rx_8n1 #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rx        (rx),
        .rxbyte    (rxbyte),
        .rxdv      (rxdv),
        .frame_err (frame_err),
        .idle      (idle)
    );

    // Record every output pulse so each scenario can look at deltas afterwards.
    always @(negedge clk) begin
        if (rxdv) begin
            dvCount++;
            byteQ.push_back(rxbyte);
        end
        if (frame_err) ferrCount++;
        if (rxdv && frame_err) bothCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] peekByte(input int back);
        if (byteQ.size() > back) return byteQ[byteQ.size() - 1 - back];
        return 8'hxx;
    endfunction

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CYC) @(negedge clk);
    endtask

    // Drives one 10-bit frame; abortKind 1 pulses rst, 2 drops en, midway through frame bit abortBit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopVal, input int abortBit, input int abortKind);
        logic [9:0] frame;
        frame = {stopVal, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (abortKind != 0 && i == abortBit) begin
                repeat (BIT_CYC / 2) @(negedge clk);
                if (abortKind == 1) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_rxbyte", {24'd0, rxbyte}, 32'h00);
                    checkOutput("rst_rxdv", {31'd0, rxdv}, 32'd0);
                    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
                    checkOutput("rst_idle", {31'd0, idle}, 32'd1);
                    @(negedge clk);
                    rst = 1'b0;
                    repeat (BIT_CYC / 2 - 1) @(negedge clk);
                end else begin
                    en = 1'b0;
                    repeat (2) @(negedge clk);
                    checkOutput("en_abort_idle", {31'd0, idle}, 32'd1);
                    repeat (BIT_CYC / 2 - 2) @(negedge clk);
                end
            end else begin
                repeat (BIT_CYC) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rxbyte", {24'd0, rxbyte}, 32'h00);
        checkOutput("reset_rxdv", {31'd0, rxdv}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_idle", {31'd0, idle}, 32'd1);
        rst = 1'b0;
        idleBits(1);

        dv0 = dvCount; fe0 = ferrCount;
        applyStimulus(8'h55, 1'b1, -1, 0);
        idleBits(1);
        checkOutput("b55_dv_count", dvCount - dv0, 32'd1);
        checkOutput("b55_byte", {24'd0, peekByte(0)}, 32'h55);
        checkOutput("b55_rxbyte", {24'd0, rxbyte}, 32'h55);
        checkOutput("b55_no_ferr", ferrCount - fe0, 32'd0);

        dv0 = dvCount; fe0 = ferrCount;
        rx = 1'b0;
        repeat (3 * CLK_DIV) @(negedge clk);
        idleBits(2);
        checkOutput("glitch_no_dv", dvCount - dv0, 32'd0);
        checkOutput("glitch_no_ferr", ferrCount - fe0, 32'd0);
        checkOutput("glitch_idle", {31'd0, idle}, 32'd1);

        dv0 = dvCount; fe0 = ferrCount;
        applyStimulus(8'h3C, 1'b0, -1, 0);
        idleBits(2);
        checkOutput("badstop_ferr", ferrCount - fe0, 32'd1);
        checkOutput("badstop_no_dv", dvCount - dv0, 32'd0);
        checkOutput("badstop_rxbyte_kept", {24'd0, rxbyte}, 32'h55);
        checkOutput("badstop_idle", {31'd0, idle}, 32'd1);

        dv0 = dvCount;
        applyStimulus(8'h7E, 1'b1, -1, 0);
        idleBits(1);
        checkOutput("b7e_dv_count", dvCount - dv0, 32'd1);
        checkOutput("b7e_byte", {24'd0, peekByte(0)}, 32'h7E);

        dv0 = dvCount;
        applyStimulus(8'hA3, 1'b1, -1, 0);
        applyStimulus(8'h00, 1'b1, -1, 0);
        idleBits(1);
        checkOutput("b2b_dv_count", dvCount - dv0, 32'd2);
        checkOutput("b2b_first", {24'd0, peekByte(1)}, 32'hA3);
        checkOutput("b2b_second", {24'd0, peekByte(0)}, 32'h00);

        dv0 = dvCount; fe0 = ferrCount;
        applyStimulus(8'hFF, 1'b1, 5, 1);
        idleBits(1);
        checkOutput("rstmid_no_dv", dvCount - dv0, 32'd0);
        checkOutput("rstmid_no_ferr", ferrCount - fe0, 32'd0);
        applyStimulus(8'h12, 1'b1, -1, 0);
        idleBits(1);
        checkOutput("b12_dv_count", dvCount - dv0, 32'd1);
        checkOutput("b12_rxbyte", {24'd0, rxbyte}, 32'h12);

        dv0 = dvCount; fe0 = ferrCount;
        applyStimulus(8'hC5, 1'b1, 5, 2);
        idleBits(1);
        checkOutput("enoff_no_dv", dvCount - dv0, 32'd0);
        checkOutput("enoff_no_ferr", ferrCount - fe0, 32'd0);
        en = 1'b1;
        idleBits(1);
        applyStimulus(8'h81, 1'b1, -1, 0);
        idleBits(1);
        checkOutput("b81_dv_count", dvCount - dv0, 32'd1);
        checkOutput("b81_byte", {24'd0, peekByte(0)}, 32'h81);

        checkOutput("never_dv_and_ferr", bothCount, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 78, meaning clk cycles per 16x-oversample tick (12 MHz / (9600*16) ~= 78.125).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: receive enable.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port rxbyte, output, 8 bits: last correctly received byte.
REQ-007 The block SHALL have port rxdv, output, 1 bit: one-cycle pulse marking a new valid byte in rxbyte.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a stop-bit error.
REQ-009 The block SHALL have port idle, output, 1 bit: high only while the FSM is in IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; the 2-cycle delay is part of the latency.
REQ-011 The tick counter SHALL count 0..CLK_DIV-1, emit a one-cycle tick at wrap, and reset to 0 whenever the FSM enters START.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK; the encoding is free.
REQ-013 IDLE -> START SHALL occur on a synchronized falling edge of rx while en=1.
REQ-014 Per bit, the tick index SHALL count 0..15; the bit value SHALL be the majority vote of the samples at ticks 7, 8 and 9, decided at tick 9.
REQ-015 In START, a voted 1 SHALL be treated as a false start: return to IDLE with no output activity.
REQ-016 In START, a voted 0 SHALL lead to DATA after tick 15.
REQ-017 DATA SHALL shift in 8 bits LSB-first into an internal shift register, then go to STOP.
REQ-018 In STOP, a voted 1 SHALL load rxbyte from the shift register and pulse rxdv on the cycle after the decision, then return to IDLE without waiting for the end of the stop bit.
REQ-019 In STOP, a voted 0 SHALL pulse frame_err for one cycle, leave rxbyte unchanged, suppress rxdv, and go to BREAK.
REQ-020 BREAK SHALL stay until the synchronized rx is high for 16 consecutive ticks, then go to IDLE; one break SHALL give exactly one frame_err.
REQ-021 rxbyte SHALL hold its value until the next valid frame; there is no consumer handshake, and a missed rxdv is lost.
REQ-022 rxdv and frame_err SHALL never be high in the same cycle.
REQ-023 en falling mid-frame SHALL abort the frame and force IDLE on the next cycle, with no rxdv and no frame_err.
REQ-024 A falling edge arriving in the same cycle as the return to IDLE SHALL be accepted as a new start, so back-to-back frames are not lost.

Reset
REQ-025 rst SHALL asynchronously force: FSM=IDLE, counters=0, shift register=0, rxbyte=8'h00, rxdv=0, frame_err=0, idle=1, synchronizer flops=1.
REQ-026 After rst deasserts mid-frame, the remaining bits of that frame SHALL be ignored until a falling edge is seen from a high line.

Structure
REQ-027 The shared package uart_pkg SHALL hold the FSM state type, OVERSAMPLE=16, DATA_BITS=8 and the default CLK_DIV.
REQ-028 The tick generator SHALL be the sub-module uart_baud_tick (ports clk, rst, clr, tick), sized for reuse by a future tick-based transmitter.

Verification
REQ-029 Send 0x55 at 9600 baud, 8N1 -> exactly one rxdv; rxbyte=0x55; frame_err never high.
REQ-030 Send 0xA3 then 0x00 back-to-back with no idle gap -> two rxdv pulses, carrying 0xA3 then 0x00.
REQ-031 Drive rx low for 3 oversample ticks (a glitch) -> no rxdv, no frame_err, idle returns to 1.
REQ-032 Send 0x3C with the stop bit held low, then release the line -> one frame_err pulse, no rxdv, rxbyte keeps its previous value; then send 0x7E -> rxdv with 0x7E.
REQ-033 Assert rst at data bit 4 of 0xFF -> all outputs return to reset values at once; the next 0x12 is received correctly.
REQ-034 Deassert en mid-frame -> no outputs fire; reassert en and send 0x81 -> rxdv with 0x81.
